// File: rtl/wb_data_stage.sv
// Registered MIPS writeback stage: GRF write-data select, load extension, mult/div wait FSM.
// Optional misaligned-load detection (adel output) is enabled by defining WB_ALIGN_CHECK_EN.
module wb_data_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int PC_OFFSET = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              m_valid,
    input  logic [2:0]        wd_sel,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] dm_out,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] cp0_out,
    input  logic [DATA_W-1:0] md_out,
    input  logic              md_busy,
    input  logic              m_we,
    input  logic [REG_AW-1:0] m_waddr,
    output logic              stall_req,
    output logic              w_valid,
    output logic              w_we,
    output logic [REG_AW-1:0] w_waddr,
    output logic [DATA_W-1:0] w_wd,
    output logic [CNT_W-1:0]  md_wait_cnt
`ifdef WB_ALIGN_CHECK_EN
    ,
    output logic              adel
`endif
);

    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_DM  = 3'd1;
    localparam logic [2:0] SEL_PC  = 3'd2;
    localparam logic [2:0] SEL_CP0 = 3'd3;
    localparam logic [2:0] SEL_MD  = 3'd4;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic                w_valid_q, w_valid_d;
    logic                w_we_q, w_we_d;
    logic [REG_AW-1:0]   w_waddr_q, w_waddr_d;
    logic [DATA_W-1:0]   w_wd_q, w_wd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                adel_q, adel_d;

    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   dm_ext;
    logic [DATA_W-1:0]   sel_data;
    logic                md_start;
    logic                misaligned;

    assign md_start = m_valid && (wd_sel == SEL_MD) && md_busy;

    always_comb begin
        ld_byte = dm_out[7:0];
        case (addr_lo)
            2'd0:    ld_byte = dm_out[7:0];
            2'd1:    ld_byte = dm_out[15:8];
            2'd2:    ld_byte = dm_out[23:16];
            default: ld_byte = dm_out[31:24];
        endcase
        ld_half = addr_lo[1] ? dm_out[31:16] : dm_out[15:0];

        case (ld_type)
            LD_LB:   dm_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            LD_LBU:  dm_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            LD_LH:   dm_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            LD_LHU:  dm_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: dm_ext = dm_out;
        endcase

        // Bytes are always aligned; halves need bit 0 clear; everything else is a word.
        case (ld_type)
            LD_LB, LD_LBU: misaligned = 1'b0;
            LD_LH, LD_LHU: misaligned = addr_lo[0];
            default:       misaligned = (addr_lo != 2'd0);
        endcase
    end

    always_comb begin
        case (wd_sel)
            SEL_ALU: sel_data = alu_out;
            SEL_DM:  sel_data = dm_ext;
            SEL_PC:  sel_data = pc + DATA_W'(PC_OFFSET);
            SEL_CP0: sel_data = cp0_out;
            SEL_MD:  sel_data = md_out;
            default: sel_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        w_valid_d = w_valid_q;
        w_we_d    = w_we_q;
        w_waddr_d = w_waddr_q;
        w_wd_d    = w_wd_q;
        cnt_d     = cnt_q;
        adel_d    = adel_q;

        if (flush) begin
            w_valid_d = 1'b0;
            w_we_d    = 1'b0;
            adel_d    = 1'b0;
            state_d   = ST_IDLE;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    adel_d = 1'b0;
                    if (md_start) begin
                        w_valid_d = 1'b0;
                        w_we_d    = 1'b0;
                        state_d   = ST_WAIT;
                    end else begin
                        w_valid_d = m_valid;
                        w_we_d    = m_valid && m_we;
                        w_waddr_d = m_waddr;
                        w_wd_d    = sel_data;
`ifdef WB_ALIGN_CHECK_EN
                        if (m_valid && (wd_sel == SEL_DM) && misaligned) begin
                            adel_d = 1'b1;
                            w_we_d = 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    adel_d = 1'b0;
                    if (md_busy) begin
                        w_valid_d = 1'b0;
                        w_we_d    = 1'b0;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        w_valid_d = 1'b1;
                        w_we_d    = m_we;
                        w_waddr_d = m_waddr;
                        w_wd_d    = md_out;
                        state_d   = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            w_valid_q <= 1'b0;
            w_we_q    <= 1'b0;
            w_waddr_q <= '0;
            w_wd_q    <= '0;
            cnt_q     <= '0;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_valid_q <= w_valid_d;
            w_we_q    <= w_we_d;
            w_waddr_q <= w_waddr_d;
            w_wd_q    <= w_wd_d;
            cnt_q     <= cnt_d;
            adel_q    <= adel_d;
        end
    end

    // Stall drops in the same cycle md_busy falls so upstream advances with the capture.
    assign stall_req = ((state_q == ST_WAIT) && md_busy) || ((state_q == ST_IDLE) && md_start);

    assign w_valid     = w_valid_q;
    assign w_we        = w_we_q;
    assign w_waddr     = w_waddr_q;
    assign w_wd        = w_wd_q;
    assign md_wait_cnt = cnt_q;
`ifdef WB_ALIGN_CHECK_EN
    assign adel        = adel_q;
`else
    logic unused_align;
    assign unused_align = adel_q ^ adel_d ^ misaligned;
`endif

endmodule

// File: tb/tb_wb_data_stage.sv
// Directed self-checking bench for wb_data_stage; adel checks compile in with WB_ALIGN_CHECK_EN.
module tb_wb_data_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset, en, flush, m_valid;
    logic [2:0]        wd_sel, ld_type;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] alu_out, dm_out, pc, cp0_out, md_out;
    logic              md_busy, m_we;
    logic [REG_AW-1:0] m_waddr;
    logic              stall_req, w_valid, w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [DATA_W-1:0] w_wd;
    logic [CNT_W-1:0]  md_wait_cnt;
`ifdef WB_ALIGN_CHECK_EN
    logic              adel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_data_stage #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_OFFSET(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .m_valid(m_valid),
        .wd_sel(wd_sel), .ld_type(ld_type), .addr_lo(addr_lo),
        .alu_out(alu_out), .dm_out(dm_out), .pc(pc), .cp0_out(cp0_out), .md_out(md_out),
        .md_busy(md_busy), .m_we(m_we), .m_waddr(m_waddr),
        .stall_req(stall_req), .w_valid(w_valid), .w_we(w_we), .w_waddr(w_waddr),
        .w_wd(w_wd), .md_wait_cnt(md_wait_cnt)
`ifdef WB_ALIGN_CHECK_EN
        , .adel(adel)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] sel, input logic [2:0] ld,
                                 input logic [1:0] lo, input logic we,
                                 input logic [REG_AW-1:0] waddr);
        m_valid = 1'b1;
        wd_sel  = sel;
        ld_type = ld;
        addr_lo = lo;
        m_we    = we;
        m_waddr = waddr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; m_valid = 1'b0;
        wd_sel = 3'd0; ld_type = 3'd0; addr_lo = 2'd0;
        alu_out = 32'h0; dm_out = 32'h0; pc = 32'h0; cp0_out = 32'h0; md_out = 32'h0;
        md_busy = 1'b0; m_we = 1'b0; m_waddr = '0;
        tick();
        tick();
        checkOutput("rst_valid", 32'(w_valid), 32'd0);
        checkOutput("rst_we", 32'(w_we), 32'd0);
        checkOutput("rst_waddr", 32'(w_waddr), 32'd0);
        checkOutput("rst_wd", w_wd, 32'h0);
        checkOutput("rst_cnt", 32'(md_wait_cnt), 32'd0);
        checkOutput("rst_stall", 32'(stall_req), 32'd0);

        // Link write: pc + 8
        reset = 1'b0; en = 1'b1;
        pc = 32'h0000_3000;
        applyStimulus(3'd2, 3'd0, 2'd0, 1'b1, 5'd31);
        tick();
        checkOutput("link_wd", w_wd, 32'h0000_3008);
        checkOutput("link_waddr", 32'(w_waddr), 32'd31);
        checkOutput("link_we", 32'(w_we), 32'd1);
        checkOutput("link_valid", 32'(w_valid), 32'd1);

        // Load extension on dm_out = 80 F1 7F 02
        dm_out = 32'h80F1_7F02;
        applyStimulus(3'd1, 3'd1, 2'd1, 1'b1, 5'd4);
        tick();
        checkOutput("lb_a1", w_wd, 32'h0000_007F);
        checkOutput("lb_a1_waddr", 32'(w_waddr), 32'd4);
        addr_lo = 2'd2;
        tick();
        checkOutput("lb_a2", w_wd, 32'hFFFF_FFF1);
        ld_type = 3'd4;
        tick();
        checkOutput("lhu_a2", w_wd, 32'h0000_80F1);
        ld_type = 3'd3;
        tick();
        checkOutput("lh_a2", w_wd, 32'hFFFF_80F1);
        addr_lo = 2'd0;
        tick();
        checkOutput("lh_a0", w_wd, 32'h0000_7F02);
        ld_type = 3'd2; addr_lo = 2'd3;
        tick();
        checkOutput("lbu_a3", w_wd, 32'h0000_0080);
        ld_type = 3'd0; addr_lo = 2'd0;
        tick();
        checkOutput("lw_a0", w_wd, 32'h80F1_7F02);
        ld_type = 3'd6;
        tick();
        checkOutput("lw_type6", w_wd, 32'h80F1_7F02);

        // Mult/div wait: three busy cycles
        md_out = 32'h1234_5678;
        applyStimulus(3'd4, 3'd0, 2'd0, 1'b1, 5'd9);
        md_busy = 1'b1;
        #1;
        checkOutput("md_stall_idle", 32'(stall_req), 32'd1);
        tick();
        checkOutput("md_b1_valid", 32'(w_valid), 32'd0);
        checkOutput("md_b1_stall", 32'(stall_req), 32'd1);
        tick();
        checkOutput("md_b2_valid", 32'(w_valid), 32'd0);
        checkOutput("md_b2_stall", 32'(stall_req), 32'd1);
        tick();
        checkOutput("md_b3_valid", 32'(w_valid), 32'd0);
        checkOutput("md_b3_we", 32'(w_we), 32'd0);
        md_busy = 1'b0;
        #1;
        checkOutput("md_stall_drop", 32'(stall_req), 32'd0);
        tick();
        checkOutput("md_wd", w_wd, 32'h1234_5678);
        checkOutput("md_valid", 32'(w_valid), 32'd1);
        checkOutput("md_we", 32'(w_we), 32'd1);
        checkOutput("md_waddr", 32'(w_waddr), 32'd9);
        checkOutput("md_cnt", 32'(md_wait_cnt), 32'd2);

        // Flush while in WAIT returns to IDLE without counting
        md_busy = 1'b1; m_waddr = 5'd10;
        tick();
        checkOutput("fl_enter_valid", 32'(w_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl_valid", 32'(w_valid), 32'd0);
        checkOutput("fl_we", 32'(w_we), 32'd0);
        checkOutput("fl_cnt", 32'(md_wait_cnt), 32'd2);
        m_valid = 1'b0;
        #1;
        checkOutput("fl_stall", 32'(stall_req), 32'd0);
        // In IDLE the ALU source is taken; a stuck WAIT would capture md_out
        alu_out = 32'hAAAA_5555; md_busy = 1'b0;
        applyStimulus(3'd0, 3'd0, 2'd0, 1'b1, 5'd3);
        tick();
        checkOutput("fl_idle_wd", w_wd, 32'hAAAA_5555);
        checkOutput("fl_idle_waddr", 32'(w_waddr), 32'd3);

        // en=0 holds everything
        en = 1'b0; alu_out = 32'h1111_1111; m_waddr = 5'd7; m_we = 1'b0;
        tick();
        tick();
        checkOutput("hold_wd", w_wd, 32'hAAAA_5555);
        checkOutput("hold_waddr", 32'(w_waddr), 32'd3);
        checkOutput("hold_we", 32'(w_we), 32'd1);
        checkOutput("hold_valid", 32'(w_valid), 32'd1);
        en = 1'b1;

        // Reserved select writes zero; CP0 select
        applyStimulus(3'd6, 3'd0, 2'd0, 1'b1, 5'd12);
        tick();
        checkOutput("rsv_wd", w_wd, 32'h0);
        checkOutput("rsv_we", 32'(w_we), 32'd1);
        cp0_out = 32'hC0C0_0001;
        applyStimulus(3'd3, 3'd0, 2'd0, 1'b1, 5'd13);
        tick();
        checkOutput("cp0_wd", w_wd, 32'hC0C0_0001);

        // Write-enable gating
        applyStimulus(3'd0, 3'd0, 2'd0, 1'b0, 5'd14);
        tick();
        checkOutput("nowe_we", 32'(w_we), 32'd0);
        checkOutput("nowe_valid", 32'(w_valid), 32'd1);
        m_valid = 1'b0; m_we = 1'b1;
        tick();
        checkOutput("bubble_we", 32'(w_we), 32'd0);
        checkOutput("bubble_valid", 32'(w_valid), 32'd0);

        // Counter saturates at 2^CNT_W-1 (3 here)
        applyStimulus(3'd4, 3'd0, 2'd0, 1'b1, 5'd15);
        md_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("sat_cnt", 32'(md_wait_cnt), 32'd3);
        md_busy = 1'b0;
        tick();
        checkOutput("sat_cnt_after", 32'(md_wait_cnt), 32'd3);
        checkOutput("sat_valid", 32'(w_valid), 32'd1);

`ifdef WB_ALIGN_CHECK_EN
        dm_out = 32'h80F1_7F02;
        applyStimulus(3'd1, 3'd3, 2'd3, 1'b1, 5'd5);
        tick();
        checkOutput("adel_lh_set", 32'(adel), 32'd1);
        checkOutput("adel_lh_we", 32'(w_we), 32'd0);
        checkOutput("adel_lh_valid", 32'(w_valid), 32'd1);
        applyStimulus(3'd1, 3'd0, 2'd0, 1'b1, 5'd5);
        tick();
        checkOutput("adel_lw_clr", 32'(adel), 32'd0);
        checkOutput("adel_lw_we", 32'(w_we), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
